moore_pattern_gen: RTL and testbench

Serial pattern transmitter: a Moore FSM that shifts a programmable PAT_W-bit pattern out on a single-bit line, MSB first. It repeats the pattern a configurable number of times, with an optional idle gap between repetitions. It sits on the transmit side of the `moore_machine` sequence detector, driving that block's `in` port in system-level and loopback tests. All outputs are registered functions of state only (Moore).

---
 rtl/moore_pkg.sv | 13 +
 rtl/pattern_shift_reg.sv | 19 +
 rtl/moore_pattern_gen.sv | 100 ++++++++++
 tb/tb_moore_pattern_gen.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/moore_pkg.sv
// moore_pkg: state encoding, default pattern and widths shared by the pattern generator and detector
package moore_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;
  localparam int PAT_W = 4;
  localparam int REP_W = 4;
  localparam int GAP_W = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1011;
endpackage

// File: rtl/pattern_shift_reg.sv
// pattern_shift_reg: parallel-load left-shift register with MSB tap
module pattern_shift_reg #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] din,
  output logic             msb
);
  logic [PAT_W-1:0] q;
  // load wins over shift so a back-to-back reload restarts the pattern cleanly
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= '0;
    else if (load) q <= din;
    else if (shift) q <= {q[PAT_W-2:0], 1'b0};
  assign msb = q[PAT_W-1];
endmodule

// File: rtl/moore_pattern_gen.sv
// moore_pattern_gen: Moore FSM shifting a repeated pattern out MSB first with optional idle gaps
module moore_pattern_gen #(
  parameter int               PAT_W       = moore_pkg::PAT_W,
  parameter logic [PAT_W-1:0] DEF_PATTERN = PAT_W'(moore_pkg::DEF_PATTERN),
  parameter int               REP_W       = moore_pkg::REP_W,
  parameter int               GAP_W       = moore_pkg::GAP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [REP_W-1:0] cfg_reps,
  input  logic [GAP_W-1:0] cfg_gap,
  input  logic             abort,
  output logic             out,
  output logic             busy,
  output logic             done
);
  import moore_pkg::*;
  localparam int BW = $clog2(PAT_W);
  localparam logic [BW-1:0] LAST = BW'(PAT_W - 1);
  state_t state, state_n;
  logic [PAT_W-1:0] pat_cfg, pat_src;
  logic [REP_W-1:0] reps_cfg, reps_eff, rep_cnt;
  logic [GAP_W-1:0] gap_cfg, gap_eff, gap_w, gap_cnt;
  logic [BW-1:0] bit_cnt;
  logic go, last_bit, more, gap_end, load, msb;
  assign go       = state == IDLE && start;
  assign last_bit = bit_cnt == '0;
  assign more     = rep_cnt != '0;
  assign gap_end  = gap_cnt <= GAP_W'(1);
  assign pat_src  = state == IDLE && cfg_we ? cfg_pattern : pat_cfg;
  assign reps_eff = cfg_we ? cfg_reps : reps_cfg;
  assign gap_eff  = cfg_we ? cfg_gap : gap_cfg;
  assign load     = go || (state == SEND && last_bit && more && gap_w == '0) || (state == GAP && gap_end);
  pattern_shift_reg #(.PAT_W(PAT_W)) u_shift (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (state == SEND),
    .din   (pat_src),
    .msb   (msb)
  );
  // state register; reset drops straight to IDLE, aborting any transfer without done
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  // next-state and Moore output decode
  always_comb begin
    state_n = state;
    out     = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: state_n = start ? SEND : IDLE;
      SEND: begin
        state_n = abort ? IDLE : !last_bit ? SEND : !more ? DONE : gap_w != '0 ? GAP : SEND;
        out     = msb;
        busy    = 1'b1;
      end
      GAP: begin
        state_n = abort ? IDLE : gap_end ? SEND : GAP;
        busy    = 1'b1;
      end
      DONE: begin
        state_n = IDLE;
        done    = 1'b1;
      end
    endcase
  end
  // config registers plus working counters; counters only step down while nonzero
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pat_cfg  <= DEF_PATTERN;
      reps_cfg <= REP_W'(1);
      gap_cfg  <= '0;
      rep_cnt  <= '0;
      gap_w    <= '0;
      gap_cnt  <= '0;
      bit_cnt  <= '0;
    end else begin
      if (state == IDLE && cfg_we) begin
        pat_cfg  <= cfg_pattern;
        reps_cfg <= cfg_reps;
        gap_cfg  <= cfg_gap;
      end
      if (go) begin
        bit_cnt <= LAST;
        rep_cnt <= reps_eff == '0 ? '0 : reps_eff - 1'b1;
        gap_w   <= gap_eff;
      end else if (state == SEND) begin
        bit_cnt <= last_bit ? LAST : bit_cnt - 1'b1;
        if (last_bit && more) begin
          rep_cnt <= rep_cnt - 1'b1;
          gap_cnt <= gap_w;
        end
      end else if (state == GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
    end
endmodule

// File: tb/tb_moore_pattern_gen.sv
// tb_moore_pattern_gen: randomized and directed checks of moore_pattern_gen against a stream model
module tb_moore_pattern_gen;
  logic clk = 0, rst = 0, start = 0, cfg_we = 0, abort = 0;
  logic [3:0] cfg_pattern = 0, cfg_reps = 0, cfg_gap = 0;
  logic out, busy, done;
  int checks = 0, errors = 0;
  logic [3:0] m_pat = 4'b1011;
  int m_reps = 1, m_gap = 0;
  logic [2:0] eq[$];

  moore_pattern_gen dut (
    .clk(clk), .rst(rst), .start(start), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_reps(cfg_reps), .cfg_gap(cfg_gap),
    .abort(abort), .out(out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // expected {out,busy,done} per cycle after the start edge, ending with one idle cycle
  function automatic void build(input logic [3:0] p, input int reps, input int gap);
    int r;
    r = reps == 0 ? 1 : reps;
    eq.delete();
    for (int k = 0; k < r; k++) begin
      for (int b = 3; b >= 0; b--) eq.push_back({p[b], 2'b10});
      if (k < r - 1) for (int g = 0; g < gap; g++) eq.push_back(3'b010);
    end
    eq.push_back(3'b001);
    eq.push_back(3'b000);
  endfunction

  task automatic kick(input logic we, input logic [3:0] p, input logic [3:0] r, input logic [3:0] g);
    cfg_we = we; cfg_pattern = p; cfg_reps = r; cfg_gap = g; start = 1;
    if (we) begin m_pat = p; m_reps = r; m_gap = g; end
    @(posedge clk); #1;
    cfg_we = 0; start = 0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({out, busy, done} !== 3'b000) begin errors++; $display("FAIL reset_hold got %b exp 000", {out, busy, done}); end
    rst = 1;
    @(negedge clk);
    checks++;
    if ({out, busy, done} !== 3'b000) begin errors++; $display("FAIL reset_release got %b exp 000", {out, busy, done}); end
  endtask

  task automatic test_defaults;
    kick(0, 0, 0, 0);
    build(m_pat, m_reps, m_gap);
    for (int i = 0; i < eq.size(); i++) begin
      if (i > 0) @(negedge clk);
      else @(negedge clk);
      checks++;
      if ({out, busy, done} !== eq[i]) begin errors++; $display("FAIL defaults cyc%0d got %b exp %b", i, {out, busy, done}, eq[i]); end
    end
  endtask

  task automatic test_gap;
    cfg_we = 1; cfg_pattern = 4'b0110; cfg_reps = 2; cfg_gap = 3;
    m_pat = 4'b0110; m_reps = 2; m_gap = 3;
    @(negedge clk);
    cfg_we = 0; cfg_pattern = 0; cfg_reps = 0; cfg_gap = 0;
    kick(0, 0, 0, 0);
    build(m_pat, m_reps, m_gap);
    for (int i = 0; i < eq.size(); i++) begin
      @(negedge clk);
      checks++;
      if ({out, busy, done} !== eq[i]) begin errors++; $display("FAIL gap cyc%0d got %b exp %b", i, {out, busy, done}, eq[i]); end
    end
  endtask

  task automatic test_back_to_back;
    for (int t = 0; t < 2; t++) begin
      kick(1, 4'b0110, t == 0 ? 4'd0 : 4'd3, 4'd0);
      build(m_pat, m_reps, m_gap);
      for (int i = 0; i < eq.size(); i++) begin
        @(negedge clk);
        checks++;
        if ({out, busy, done} !== eq[i]) begin errors++; $display("FAIL b2b%0d cyc%0d got %b exp %b", t, i, {out, busy, done}, eq[i]); end
      end
    end
  endtask

  task automatic test_random;
    for (int t = 0; t < 10; t++) begin
      logic [3:0] p, r, g;
      p = 4'($urandom);
      r = 4'($urandom_range(0, 4));
      g = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) kick(1, p, r, g);
      else begin
        cfg_we = 1; cfg_pattern = p; cfg_reps = r; cfg_gap = g;
        m_pat = p; m_reps = r; m_gap = g;
        @(negedge clk);
        cfg_we = 0; cfg_pattern = ~p;
        kick(0, 0, 0, 0);
      end
      build(m_pat, m_reps, m_gap);
      for (int i = 0; i < eq.size(); i++) begin
        @(negedge clk);
        checks++;
        if ({out, busy, done} !== eq[i]) begin errors++; $display("FAIL rand%0d p=%b r=%0d g=%0d cyc%0d got %b exp %b", t, m_pat, m_reps, m_gap, i, {out, busy, done}, eq[i]); end
      end
    end
  endtask

  task automatic test_abort;
    kick(1, 4'b0110, 4'd2, 4'd1);
    @(negedge clk);
    checks++;
    if ({out, busy, done} !== 3'b010) begin errors++; $display("FAIL abort_bit0 got %b exp 010", {out, busy, done}); end
    @(negedge clk);
    checks++;
    if ({out, busy, done} !== 3'b110) begin errors++; $display("FAIL abort_bit1 got %b exp 110", {out, busy, done}); end
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({out, busy, done} !== 3'b000) begin errors++; $display("FAIL abort_idle%0d got %b exp 000", i, {out, busy, done}); end
    end
    kick(0, 0, 0, 0);
    build(m_pat, m_reps, m_gap);
    for (int i = 0; i < eq.size(); i++) begin
      @(negedge clk);
      checks++;
      if ({out, busy, done} !== eq[i]) begin errors++; $display("FAIL after_abort cyc%0d got %b exp %b", i, {out, busy, done}, eq[i]); end
    end
  endtask

  task automatic test_ignored;
    kick(1, 4'b1001, 4'd2, 4'd2);
    build(m_pat, m_reps, m_gap);
    for (int i = 0; i < eq.size(); i++) begin
      @(negedge clk);
      checks++;
      if ({out, busy, done} !== eq[i]) begin errors++; $display("FAIL ignored cyc%0d got %b exp %b", i, {out, busy, done}, eq[i]); end
      if (i == 2 || i == eq.size() - 2) begin
        cfg_we = 1; start = 1; cfg_pattern = 4'b1111; cfg_reps = 4'd5; cfg_gap = 4'd0;
      end else begin
        cfg_we = 0; start = 0;
      end
    end
    kick(0, 0, 0, 0);
    build(m_pat, m_reps, m_gap);
    for (int i = 0; i < eq.size(); i++) begin
      @(negedge clk);
      checks++;
      if ({out, busy, done} !== eq[i]) begin errors++; $display("FAIL cfg_kept cyc%0d got %b exp %b", i, {out, busy, done}, eq[i]); end
    end
  endtask

  task automatic test_async_reset;
    kick(1, 4'b1100, 4'd2, 4'd5);
    repeat (6) @(negedge clk);
    checks++;
    if ({out, busy, done} !== 3'b010) begin errors++; $display("FAIL in_gap got %b exp 010", {out, busy, done}); end
    #2 rst = 0;
    #1;
    checks++;
    if ({out, busy, done} !== 3'b000) begin errors++; $display("FAIL async_clear got %b exp 000", {out, busy, done}); end
    @(negedge clk);
    rst = 1;
    m_pat = 4'b1011; m_reps = 1; m_gap = 0;
    @(negedge clk);
    kick(0, 0, 0, 0);
    build(m_pat, m_reps, m_gap);
    for (int i = 0; i < eq.size(); i++) begin
      @(negedge clk);
      checks++;
      if ({out, busy, done} !== eq[i]) begin errors++; $display("FAIL post_reset cyc%0d got %b exp %b", i, {out, busy, done}, eq[i]); end
    end
  endtask

  initial begin
    test_reset;
    test_defaults;
    test_gap;
    test_back_to_back;
    test_random;
    test_abort;
    test_ignored;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
